unidade_controle_jogo: RTL and testbench



---
 rtl/unidade_controle_jogo.sv | 148 ++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// Control FSM for the memory-sequence game datapath.
// Each round replays the stored sequence on the LEDs, checks the player's
// plays against it and then captures one new play. A per-play timeout makes
// the player lose. Moore outputs; every strobe lasts one cycle per visit.
module unidade_controle_jogo #(
   parameter int DISPLAY_CYCLES = 1000,
   parameter int GAP_CYCLES     = 500,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       tem_jogada,
   input  logic       igual,
   input  logic       enderecoIgualRodada,
   input  logic       fimR,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraR,
   output logic       contaR,
   output logic       registraR,
   output logic       escreveM,
   output logic       mostra_leds,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [4:0] db_estado
);

   typedef enum logic [4:0] {
      INICIAL       = 5'h00,
      PREPARA       = 5'h01,
      INICIA_RODADA = 5'h02,
      MOSTRA        = 5'h03,
      APAGA         = 5'h04,
      PROX_MOSTRA   = 5'h05,
      ZERA_JOGO     = 5'h06,
      ESPERA        = 5'h07,
      REGISTRA      = 5'h08,
      COMPARA       = 5'h09,
      PROX_JOGADA   = 5'h0A,
      INCR_NOVA     = 5'h0B,
      ESPERA_NOVA   = 5'h0C,
      ESCREVE       = 5'h0D,
      PROX_RODADA   = 5'h0E,
      GANHOU        = 5'h0F,
      PERDEU        = 5'h10,
      TIMEOUT       = 5'h11
   } estado_t;

   // Last timer value of each timed interval.
   localparam logic [15:0] FIM_MOSTRA = 16'(DISPLAY_CYCLES - 1);
   localparam logic [15:0] FIM_APAGA  = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] FIM_ESPERA = 16'(TIMEOUT_CYCLES - 1);

   estado_t     r_estado;
   estado_t     w_prox;
   logic [15:0] r_timer;
   logic        w_temporizado;

   assign w_temporizado = (r_estado == MOSTRA) || (r_estado == APAGA) ||
                          (r_estado == ESPERA) || (r_estado == ESPERA_NOVA);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_estado <= INICIAL;
      else       r_estado <= w_prox;
   end

   // Shared interval timer: zero on entering a state, counts while a timed state holds.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                   r_timer <= '0;
      else if (w_prox != r_estado) r_timer <= '0;
      else if (w_temporizado)      r_timer <= r_timer + 16'd1;
   end

   // Next-state logic.
   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         INICIAL:       if (iniciar) w_prox = PREPARA;
         PREPARA:       w_prox = INICIA_RODADA;
         INICIA_RODADA: w_prox = MOSTRA;
         MOSTRA:        if (r_timer == FIM_MOSTRA) w_prox = APAGA;
         APAGA:         if (r_timer == FIM_APAGA)
                           w_prox = enderecoIgualRodada ? ZERA_JOGO : PROX_MOSTRA;
         PROX_MOSTRA:   w_prox = MOSTRA;
         ZERA_JOGO:     w_prox = ESPERA;
         ESPERA: begin
            // A press on the expiry cycle still counts as a play.
            if (tem_jogada)                  w_prox = REGISTRA;
            else if (r_timer == FIM_ESPERA)  w_prox = TIMEOUT;
         end
         REGISTRA:      w_prox = COMPARA;
         COMPARA: begin
            if (!igual)                    w_prox = PERDEU;
            else if (!enderecoIgualRodada) w_prox = PROX_JOGADA;
            else if (fimR)                 w_prox = GANHOU;
            else                           w_prox = INCR_NOVA;
         end
         PROX_JOGADA:   w_prox = ESPERA;
         INCR_NOVA:     w_prox = ESPERA_NOVA;
         ESPERA_NOVA: begin
            if (tem_jogada)                  w_prox = ESCREVE;
            else if (r_timer == FIM_ESPERA)  w_prox = TIMEOUT;
         end
         ESCREVE:       w_prox = PROX_RODADA;
         PROX_RODADA:   w_prox = INICIA_RODADA;
         GANHOU, PERDEU, TIMEOUT: if (iniciar) w_prox = PREPARA;
         default:       w_prox = INICIAL;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      zeraE       = 1'b0;
      contaE      = 1'b0;
      zeraR       = 1'b0;
      contaR      = 1'b0;
      registraR   = 1'b0;
      escreveM    = 1'b0;
      mostra_leds = 1'b0;
      pronto      = 1'b0;
      ganhou      = 1'b0;
      perdeu      = 1'b0;
      db_timeout  = 1'b0;
      case (r_estado)
         PREPARA:       begin zeraE = 1'b1; zeraR = 1'b1; end
         INICIA_RODADA: zeraE = 1'b1;
         MOSTRA:        mostra_leds = 1'b1;
         PROX_MOSTRA:   contaE = 1'b1;
         ZERA_JOGO:     zeraE = 1'b1;
         REGISTRA:      registraR = 1'b1;
         PROX_JOGADA:   contaE = 1'b1;
         INCR_NOVA:     contaE = 1'b1;
         ESCREVE:       begin registraR = 1'b1; escreveM = 1'b1; end
         PROX_RODADA:   contaR = 1'b1;
         GANHOU:        begin pronto = 1'b1; ganhou = 1'b1; end
         PERDEU:        begin pronto = 1'b1; perdeu = 1'b1; end
         TIMEOUT:       begin pronto = 1'b1; perdeu = 1'b1; db_timeout = 1'b1; end
         default:       ;
      endcase
   end

   assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Testbench for unidade_controle_jogo. Whole games are described at the level
// of rounds and plays, expanded into an expected per-cycle state trace, and
// replayed against the DUT while a small datapath model supplies E/R status.
module tb_unidade_controle_jogo;

   localparam int D = 4;
   localparam int G = 2;
   localparam int T = 20;

   localparam int ST_INICIAL = 0,  ST_PREPARA = 1,  ST_INICIA_RODADA = 2, ST_MOSTRA = 3;
   localparam int ST_APAGA = 4,    ST_PROX_MOSTRA = 5, ST_ZERA_JOGO = 6,  ST_ESPERA = 7;
   localparam int ST_REGISTRA = 8, ST_COMPARA = 9,  ST_PROX_JOGADA = 10,  ST_INCR_NOVA = 11;
   localparam int ST_ESPERA_NOVA = 12, ST_ESCREVE = 13, ST_PROX_RODADA = 14;
   localparam int ST_GANHOU = 15,  ST_PERDEU = 16,  ST_TIMEOUT = 17;

   logic clock = 1'b0;
   logic reset, iniciar, tem_jogada, igual, enderecoIgualRodada, fimR;
   logic zeraE, contaE, zeraR, contaR, registraR, escreveM, mostra_leds;
   logic pronto, ganhou, perdeu, db_timeout;
   logic [4:0] db_estado;

   unidade_controle_jogo #(
      .DISPLAY_CYCLES(D),
      .GAP_CYCLES(G),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
      .igual(igual), .enderecoIgualRodada(enderecoIgualRodada), .fimR(fimR),
      .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .contaR(contaR),
      .registraR(registraR), .escreveM(escreveM), .mostra_leds(mostra_leds),
      .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_timeout(db_timeout),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int st;
      bit tem;
      bit ig;
      bit ini;
   } cyc_t;

   cyc_t q[$];
   int   m_e, m_r;
   int   cur;

   // {zeraE,contaE,zeraR,contaR,registraR,escreveM,mostra_leds,pronto,ganhou,perdeu,db_timeout}
   function automatic logic [10:0] exp_out(input int st);
      case (st)
         ST_PREPARA:                 return 11'b10100000000;
         ST_INICIA_RODADA:           return 11'b10000000000;
         ST_ZERA_JOGO:               return 11'b10000000000;
         ST_MOSTRA:                  return 11'b00000010000;
         ST_PROX_MOSTRA:             return 11'b01000000000;
         ST_PROX_JOGADA:             return 11'b01000000000;
         ST_INCR_NOVA:               return 11'b01000000000;
         ST_REGISTRA:                return 11'b00001000000;
         ST_ESCREVE:                 return 11'b00001100000;
         ST_PROX_RODADA:             return 11'b00010000000;
         ST_GANHOU:                  return 11'b00000001100;
         ST_PERDEU:                  return 11'b00000001010;
         ST_TIMEOUT:                 return 11'b00000001011;
         default:                    return 11'b00000000000;
      endcase
   endfunction

   function automatic logic [10:0] dut_out();
      return {zeraE, contaE, zeraR, contaR, registraR, escreveM, mostra_leds,
              pronto, ganhou, perdeu, db_timeout};
   endfunction

   task automatic push(input int st, input bit tem = 1'b0, input bit ig = 1'b0,
                       input bit ini = 1'b0);
      cyc_t c;
      c.st = st; c.tem = tem; c.ig = ig; c.ini = ini;
      q.push_back(c);
   endtask

   // Waiting for a play: w idle cycles then a press, or a full timeout.
   task automatic add_wait(input int st, input int w, input bit to);
      if (to) begin
         repeat (T) push(st);
         push(ST_TIMEOUT);
      end else begin
         repeat (w) push(st);
         push(st, 1'b1);
      end
   endtask

   function automatic int rand_wait();
      return ($urandom_range(0, 3) == 0) ? T - 1 : int'($urandom_range(0, T - 1));
   endfunction

   // kind: 0 win (last=15), 1 wrong play p, 2 timeout at play p, 3 timeout awaiting new play.
   task automatic build_game(input int start, input int last, input int kind, input int p);
      q.delete();
      push(start, 1'b0, 1'b0, 1'b1);
      push(ST_PREPARA);
      for (int r = 0; r <= last; r++) begin
         push(ST_INICIA_RODADA);
         for (int i = 0; i <= r; i++) begin
            repeat (D) push(ST_MOSTRA);
            repeat (G) push(ST_APAGA);
            if (i < r) push(ST_PROX_MOSTRA);
         end
         push(ST_ZERA_JOGO);
         for (int j = 0; j <= r; j++) begin
            if (r == last && kind == 2 && j == p) begin
               add_wait(ST_ESPERA, 0, 1'b1);
               return;
            end
            add_wait(ST_ESPERA, rand_wait(), 1'b0);
            push(ST_REGISTRA);
            if (r == last && kind == 1 && j == p) begin
               push(ST_COMPARA, 1'b0, 1'b0);
               push(ST_PERDEU);
               return;
            end
            push(ST_COMPARA, 1'b0, 1'b1);
            if (j < r) push(ST_PROX_JOGADA);
         end
         if (r == 15) begin
            push(ST_GANHOU);
            return;
         end
         push(ST_INCR_NOVA);
         if (r == last && kind == 3) begin
            add_wait(ST_ESPERA_NOVA, 0, 1'b1);
            return;
         end
         add_wait(ST_ESPERA_NOVA, rand_wait(), 1'b0);
         push(ST_ESCREVE);
         push(ST_PROX_RODADA);
      end
   endtask

   task automatic hold(input int n);
      int st;
      st = q[$].st;
      repeat (n) push(st);
   endtask

   // Replays the trace: checks each cycle, then drives that cycle's inputs.
   task automatic run_queue(input string name);
      logic [10:0] eo;
      bit waiting, stable;
      foreach (q[k]) begin
         @(negedge clock);
         checks++;
         if (db_estado !== 5'(q[k].st)) begin
            errors++;
            $display("FAIL %s estado cycle %0d: got %0h expected %0h", name, k, db_estado, q[k].st);
         end
         eo = exp_out(q[k].st);
         checks++;
         if (dut_out() !== eo) begin
            errors++;
            $display("FAIL %s saidas cycle %0d (estado %0h): got %b expected %b",
                     name, k, q[k].st, dut_out(), eo);
         end
         waiting = (q[k].st == ST_ESPERA) || (q[k].st == ST_ESPERA_NOVA);
         stable  = (q[k].st == ST_INICIAL) || (q[k].st >= ST_GANHOU);
         tem_jogada = waiting ? q[k].tem : 1'($urandom_range(0, 1));
         iniciar    = stable ? q[k].ini : 1'($urandom_range(0, 1));
         igual      = (q[k].st == ST_COMPARA) ? q[k].ig : 1'($urandom_range(0, 1));
         if (eo[10]) m_e = 0;
         else if (eo[9]) m_e = m_e + 1;
         if (eo[8]) m_r = 0;
         else if (eo[7]) m_r = m_r + 1;
         enderecoIgualRodada = (m_e == m_r);
         fimR = (m_r == 15);
      end
      cur = q[$].st;
   endtask

   task automatic test_reset();
      reset = 1'b1; iniciar = 1'b1; tem_jogada = 1'b1; igual = 1'b1;
      enderecoIgualRodada = 1'b1; fimR = 1'b0;
      m_e = 0; m_r = 0;
      repeat (3) @(negedge clock);
      checks++;
      if (db_estado !== 5'h00) begin
         errors++;
         $display("FAIL reset estado: got %0h expected 00", db_estado);
      end
      checks++;
      if (dut_out() !== 11'b0) begin
         errors++;
         $display("FAIL reset saidas: got %b expected %b", dut_out(), 11'b0);
      end
      reset = 1'b0; iniciar = 1'b0; tem_jogada = 1'b0;
      cur = ST_INICIAL;
   endtask

   task automatic test_win();
      build_game(cur, 15, 0, 0);
      hold(3);
      run_queue("win");
   endtask

   task automatic test_wrong_play();
      build_game(cur, 2, 1, 1);
      hold(2);
      run_queue("wrong_r2p1");
      begin
         int last = $urandom_range(0, 4);
         build_game(cur, last, 1, $urandom_range(0, last));
      end
      hold(2);
      run_queue("wrong_rand");
   endtask

   task automatic test_timeout();
      begin
         int last = $urandom_range(0, 3);
         build_game(cur, last, 2, $urandom_range(0, last));
      end
      hold(2);
      run_queue("timeout_espera");
      build_game(cur, $urandom_range(0, 3), 3, 0);
      hold(2);
      run_queue("timeout_nova");
   endtask

   task automatic test_back_to_back();
      for (int g = 0; g < 4; g++) begin
         int kind = $urandom_range(1, 3);
         int last = $urandom_range(0, 3);
         build_game(cur, last, kind, $urandom_range(0, last));
         run_queue("back_to_back");
      end
   endtask

   task automatic test_async_reset();
      q.delete();
      push(cur, 1'b0, 1'b0, 1'b1);
      push(ST_PREPARA);
      push(ST_INICIA_RODADA);
      push(ST_MOSTRA);
      push(ST_MOSTRA);
      run_queue("pre_async");
      #2 reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0;
      #1;
      checks++;
      if (db_estado !== 5'h00) begin
         errors++;
         $display("FAIL async_reset estado: got %0h expected 00", db_estado);
      end
      checks++;
      if (dut_out() !== 11'b0) begin
         errors++;
         $display("FAIL async_reset saidas: got %b expected %b", dut_out(), 11'b0);
      end
      @(negedge clock);
      reset = 1'b0;
      cur = ST_INICIAL;
      build_game(cur, 1, 1, 1);
      hold(2);
      run_queue("after_async");
   endtask

   initial begin
      test_reset();
      test_win();
      test_wrong_play();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
